// File: rtl/ntt_job_scheduler.sv
// NTT job scheduler: queues host commands in a small FIFO, arbitrates the
// data banks between the NTT engine and direct host access, launches jobs,
// supervises them with a cycle timeout and returns a tagged completion.
module ntt_job_scheduler #(
    parameter logic [15:0] TIMEOUT = 16'd2048,
    parameter int          DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_conf,
    input  logic [3:0] cmd_tag,
    output logic       eng_start,
    output logic [3:0] eng_conf,
    output logic       eng_abort,
    input  logic [1:0] eng_done,
    input  logic       host_req,
    output logic       host_gnt,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_tag,
    output logic [1:0] rsp_status,
    output logic       busy
);

    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [15:0]   RUN_LAST   = TIMEOUT - 16'd1;

    localparam logic OWNER_HOST = 1'b1;
    localparam logic OWNER_JOB  = 1'b0;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        HOST,
        START,
        RUN,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [3:0]    head_conf;
    logic [3:0]    head_tag;

    logic [15:0]   run_cnt;
    logic          last_owner;
    logic [3:0]    conf_q;
    logic [3:0]    tag_q;
    logic [3:0]    rsp_tag_q;
    logic [1:0]    rsp_status_q;
    logic          done_hit;
    logic          timeout_hit;

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign push       = cmd_valid && !fifo_full;
    // START is only entered with a non-empty FIFO, so the pop is always legal.
    assign pop        = (state == START);

    assign {head_conf, head_tag} = fifo_mem[rd_ptr];

    // Completion beats the timeout when both land in the same RUN cycle.
    assign done_hit    = (state == RUN) && (eng_done != 2'b00);
    assign timeout_hit = (state == RUN) && !done_hit && (run_cnt == RUN_LAST);

    // Command storage; payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_conf, cmd_tag};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic with round-robin between queued job and host access.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty && host_req) begin
                    state_nxt = (last_owner == OWNER_HOST) ? START : HOST;
                end else if (!fifo_empty) begin
                    state_nxt = START;
                end else if (host_req) begin
                    state_nxt = HOST;
                end
            end
            HOST: begin
                if (!host_req) begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (done_hit || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ownership history, run counter and job context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWNER_HOST;
            run_cnt    <= '0;
            conf_q     <= '0;
            tag_q      <= '0;
        end else begin
            if (state == HOST) begin
                last_owner <= OWNER_HOST;
            end else if (state == START) begin
                last_owner <= OWNER_JOB;
            end

            if (state == START) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + 16'd1;
            end

            // Capture the head entry so it is already on eng_conf during START.
            if ((state == IDLE) && (state_nxt == START)) begin
                conf_q <= head_conf;
                tag_q  <= head_tag;
            end
        end
    end

    // Response registers, loaded as RUN finishes and held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_tag_q    <= '0;
            rsp_status_q <= STATUS_OK;
        end else if ((state == RUN) && (state_nxt == RESP)) begin
            rsp_tag_q    <= tag_q;
            rsp_status_q <= done_hit ? STATUS_OK : STATUS_TIMEOUT;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign eng_start  = (state == START);
    assign eng_conf   = conf_q;
    assign eng_abort  = timeout_hit;
    assign host_gnt   = (state == HOST);
    assign rsp_valid  = (state == RESP);
    assign rsp_tag    = rsp_tag_q;
    assign rsp_status = rsp_status_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench for ntt_job_scheduler: launch order and responses are
// predicted when commands are offered and compared as the DUT produces them.
module tb_ntt_job_scheduler;

    localparam logic [15:0] TO      = 16'd16;
    localparam logic [15:0] RST_VEC = 16'h8000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_conf;
    logic [3:0] cmd_tag;
    logic       eng_start;
    logic [3:0] eng_conf;
    logic       eng_abort;
    logic [1:0] eng_done;
    logic       host_req;
    logic       host_gnt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_tag;
    logic [1:0] rsp_status;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int excl_viol = 0;

    logic [5:0] sb[$];
    logic [3:0] lq[$];

    logic [15:0] out_vec;
    assign out_vec = {cmd_ready, eng_start, eng_abort, eng_conf, host_gnt,
                      rsp_valid, rsp_tag, rsp_status, busy};

    ntt_job_scheduler #(.TIMEOUT(TO), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_conf  (cmd_conf),
        .cmd_tag   (cmd_tag),
        .eng_start (eng_start),
        .eng_conf  (eng_conf),
        .eng_abort (eng_abort),
        .eng_done  (eng_done),
        .host_req  (host_req),
        .host_gnt  (host_gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tag   (rsp_tag),
        .rsp_status(rsp_status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (host_gnt && eng_start) excl_viol <= excl_viol + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog sim time exceeded got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic offer(input logic [3:0] conf, input logic [3:0] tag);
        cmd_valid = 1'b1;
        cmd_conf  = conf;
        cmd_tag   = tag;
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (eng_start) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic finish_job(input int d, input logic [1:0] dv);
        repeat (d) @(negedge clk);
        eng_done = dv;
        @(negedge clk);
        eng_done = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b0; cmd_valid = 1'b0; cmd_conf = '0; cmd_tag = '0;
        eng_done = 2'b00; host_req = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_vec !== RST_VEC) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", out_vec, RST_VEC);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset got busy=%b ready=%b exp busy=0 ready=1", busy, cmd_ready);
        end
    endtask

    task automatic test_single_job;
        logic [5:0] e;
        logic [3:0] c;
        rsp_ready = 1'b0;
        offer(4'h3, 4'h5); lq.push_back(4'h3); sb.push_back({4'h5, 2'b00});
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (eng_start !== 1'b0) begin
            errors++; $display("FAIL single_c1_start got %b exp 0", eng_start);
        end
        @(negedge clk);
        checks++;
        if (eng_start !== 1'b1 || host_gnt !== 1'b0) begin
            errors++; $display("FAIL single_c2_start got start=%b gnt=%b exp start=1 gnt=0", eng_start, host_gnt);
        end
        if (lq.size() > 0) begin
            c = lq.pop_front();
            checks++;
            if (eng_conf !== c) begin
                errors++; $display("FAIL single_conf got %h exp %h", eng_conf, c);
            end
        end
        finish_job(10, 2'b01);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'h5) begin
            errors++; $display("FAIL single_rsp_wait got valid=%b tag=%h exp valid=1 tag=5", rsp_valid, rsp_tag);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'h5 || rsp_status !== 2'b00) begin
            errors++; $display("FAIL single_rsp_hold got valid=%b tag=%h st=%b exp 1 5 00", rsp_valid, rsp_tag, rsp_status);
        end
        rsp_ready = 1'b1;
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL single_sb_empty got empty exp entry");
        end else begin
            e = sb.pop_front();
            if ({rsp_tag, rsp_status} !== e) begin
                errors++; $display("FAIL single_rsp got %h exp %h", {rsp_tag, rsp_status}, e);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || eng_conf !== 4'h3) begin
            errors++; $display("FAIL single_release got valid=%b busy=%b conf=%h exp 0 0 3", rsp_valid, busy, eng_conf);
        end
    endtask

    task automatic test_timeout;
        logic [5:0] e;
        logic [3:0] c;
        bit got;
        int n_abort;
        int at_k;
        n_abort = 0; at_k = 0;
        rsp_ready = 1'b1;
        offer(4'hA, 4'hA); lq.push_back(4'hA); sb.push_back({4'hA, 2'b01});
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_start(got);
        checks++;
        if (!got || lq.size() == 0) begin
            errors++; $display("FAIL timeout_start got %b exp 1", got);
        end else begin
            c = lq.pop_front();
            if (eng_conf !== c) begin
                errors++; $display("FAIL timeout_conf got %h exp %h", eng_conf, c);
            end
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (eng_abort) begin n_abort++; at_k = k; end
        end
        checks++;
        if (n_abort != 1 || at_k != 16) begin
            errors++; $display("FAIL timeout_abort got count=%0d cycle=%0d exp count=1 cycle=16", n_abort, at_k);
        end
        @(negedge clk);
        wait_rsp(got);
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL timeout_rsp_present got %b exp 1", got);
        end else begin
            e = sb.pop_front();
            if ({rsp_tag, rsp_status} !== e || eng_abort !== 1'b0) begin
                errors++; $display("FAIL timeout_rsp got %h abort=%b exp %h abort=0", {rsp_tag, rsp_status}, eng_abort, e);
            end
        end
    endtask

    task automatic test_done_at_timeout;
        logic [5:0] e;
        logic [3:0] c;
        bit got;
        int n_abort;
        n_abort = 0;
        offer(4'hB, 4'hB); lq.push_back(4'hB); sb.push_back({4'hB, 2'b00});
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_start(got);
        checks++;
        if (!got || lq.size() == 0) begin
            errors++; $display("FAIL boundary_start got %b exp 1", got);
        end else begin
            c = lq.pop_front();
            if (eng_conf !== c) begin
                errors++; $display("FAIL boundary_conf got %h exp %h", eng_conf, c);
            end
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16) eng_done = 2'b10;
            #1;
            if (eng_abort) n_abort++;
        end
        @(negedge clk);
        eng_done = 2'b00;
        checks++;
        if (n_abort != 0) begin
            errors++; $display("FAIL boundary_abort got %0d exp 0", n_abort);
        end
        wait_rsp(got);
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL boundary_rsp_present got %b exp 1", got);
        end else begin
            e = sb.pop_front();
            if ({rsp_tag, rsp_status} !== e) begin
                errors++; $display("FAIL boundary_rsp got %h exp %h", {rsp_tag, rsp_status}, e);
            end
        end
    endtask

    task automatic test_fifo_full;
        logic [5:0] e;
        logic [3:0] c;
        bit got;
        offer(4'h9, 4'h9); lq.push_back(4'h9); sb.push_back({4'h9, 2'b00});
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_start(got);
        checks++;
        if (!got || lq.size() == 0) begin
            errors++; $display("FAIL full_first_start got %b exp 1", got);
        end else begin
            c = lq.pop_front();
            if (eng_conf !== c) begin
                errors++; $display("FAIL full_first_conf got %h exp %h", eng_conf, c);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++; $display("FAIL full_ready_%0d got %b exp 1", i, cmd_ready);
            end
            offer(4'(i), 4'(i)); lq.push_back(4'(i)); sb.push_back({4'(i), 2'b00});
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL full_ready_low got ready=%b busy=%b exp ready=0 busy=1", cmd_ready, busy);
        end
        eng_done = 2'b01;
        @(negedge clk);
        eng_done = 2'b00;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                wait_start(got);
                checks++;
                if (!got || lq.size() == 0) begin
                    errors++; $display("FAIL full_order_start_%0d got %b exp 1", j, got);
                end else begin
                    c = lq.pop_front();
                    if (eng_conf !== c) begin
                        errors++; $display("FAIL full_order_%0d got %h exp %h", j, eng_conf, c);
                    end
                end
                finish_job(2, 2'b01);
            end
            wait_rsp(got);
            checks++;
            if (!got || sb.size() == 0) begin
                errors++; $display("FAIL full_rsp_present_%0d got %b exp 1", j, got);
            end else begin
                e = sb.pop_front();
                if ({rsp_tag, rsp_status} !== e) begin
                    errors++; $display("FAIL full_rsp_%0d got %h exp %h", j, {rsp_tag, rsp_status}, e);
                end
            end
        end
    endtask

    task automatic test_contention;
        logic [5:0] e;
        logic [3:0] c;
        bit got;
        bit got_gnt;
        bit saw_start;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        offer(4'h6, 4'h6); lq.push_back(4'h6); sb.push_back({4'h6, 2'b00});
        @(negedge clk);
        offer(4'h7, 4'h7); lq.push_back(4'h7); sb.push_back({4'h7, 2'b00});
        host_req = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (eng_start !== 1'b1 || host_gnt !== 1'b0) begin
            errors++; $display("FAIL contention_job_first got start=%b gnt=%b exp start=1 gnt=0", eng_start, host_gnt);
        end
        if (lq.size() > 0) begin
            c = lq.pop_front();
            checks++;
            if (eng_conf !== c) begin
                errors++; $display("FAIL contention_conf1 got %h exp %h", eng_conf, c);
            end
        end
        finish_job(2, 2'b01);
        wait_rsp(got);
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL contention_rsp1_present got %b exp 1", got);
        end else begin
            e = sb.pop_front();
            if ({rsp_tag, rsp_status} !== e) begin
                errors++; $display("FAIL contention_rsp1 got %h exp %h", {rsp_tag, rsp_status}, e);
            end
        end
        got_gnt = 1'b0; saw_start = 1'b0;
        for (int i = 0; i < 5 && !got_gnt; i++) begin
            @(negedge clk);
            if (eng_start) saw_start = 1'b1;
            if (host_gnt) got_gnt = 1'b1;
        end
        checks++;
        if (got_gnt !== 1'b1 || saw_start !== 1'b0) begin
            errors++; $display("FAIL contention_host_turn got gnt=%b start=%b exp gnt=1 start=0", got_gnt, saw_start);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1 || eng_start !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL contention_host_hold got gnt=%b start=%b busy=%b exp 1 0 1", host_gnt, eng_start, busy);
        end
        host_req = 1'b0;
        wait_start(got);
        checks++;
        if (!got || host_gnt !== 1'b0 || lq.size() == 0) begin
            errors++; $display("FAIL contention_job_again got start=%b gnt=%b exp start=1 gnt=0", got, host_gnt);
        end else begin
            c = lq.pop_front();
            if (eng_conf !== c) begin
                errors++; $display("FAIL contention_conf2 got %h exp %h", eng_conf, c);
            end
        end
        finish_job(2, 2'b01);
        wait_rsp(got);
        checks++;
        if (!got || sb.size() == 0) begin
            errors++; $display("FAIL contention_rsp2_present got %b exp 1", got);
        end else begin
            e = sb.pop_front();
            if ({rsp_tag, rsp_status} !== e) begin
                errors++; $display("FAIL contention_rsp2 got %h exp %h", {rsp_tag, rsp_status}, e);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        bit got;
        int n_rsp;
        int n_start;
        int n_abort;
        n_rsp = 0; n_start = 0; n_abort = 0;
        offer(4'hC, 4'hC);
        @(negedge clk);
        offer(4'hD, 4'hD);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_start(got);
        checks++;
        if (!got || eng_conf !== 4'hC) begin
            errors++; $display("FAIL midrun_start got start=%b conf=%h exp start=1 conf=c", got, eng_conf);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_vec !== RST_VEC) begin
            errors++; $display("FAIL midrun_reset_outputs got %h exp %h", out_vec, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
            if (eng_start) n_start++;
            if (eng_abort) n_abort++;
        end
        checks++;
        if (n_rsp != 0 || n_start != 0 || n_abort != 0) begin
            errors++; $display("FAIL midrun_after got rsp=%0d start=%0d abort=%0d exp 0 0 0", n_rsp, n_start, n_abort);
        end
    endtask

    task automatic test_drain;
        checks++;
        if (sb.size() != 0 || lq.size() != 0) begin
            errors++; $display("FAIL drain_queues got sb=%0d lq=%0d exp 0 0", sb.size(), lq.size());
        end
        checks++;
        if (excl_viol != 0) begin
            errors++; $display("FAIL gnt_start_overlap got %0d exp 0", excl_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_timeout();
        test_done_at_timeout();
        test_fifo_full();
        test_contention();
        test_reset_mid_run();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
